// File: rtl/vram_arbiter_pkg.sv
// Shared constants and grant encoding for the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int ADDR_W_DEF    = 17;
  localparam int DATA_W_DEF    = 8;

  // 320x240 frame buffer, one byte per pixel
  localparam int SCREEN_W      = 320;
  localparam int SCREEN_H      = 240;
  localparam int SCREEN_PIXELS = 76800;

  // Who owns the single VRAM port this cycle
  typedef enum logic [1:0] {
    GR_IDLE  = 2'd0,
    GR_DISP  = 2'd1,
    GR_WRITE = 2'd2,
    GR_STEAL = 2'd3
  } grant_t;

endpackage

// File: rtl/vram_arbiter_sync_fifo.sv
// Single-clock FIFO buffering CPU writes; head is visible combinationally.
module sync_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit so a full FIFO differs from an empty one
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards any buffered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since contents are gated by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win, buffered CPU writes fill the
// gaps, and a write is forced through when the buffer has been full too long.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_ready,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_valid,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        vram_we,
  output logic [ADDR_W-1:0]           vram_addr,
  output logic [DATA_W-1:0]           vram_wdata,
  input  logic [DATA_W-1:0]           vram_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 stall_cnt
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t           push_req, head;
  logic              push, pop, full, empty;
  grant_t            grant, last_grant;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  // Full flag comes straight from the FIFO pointer flops
  assign cpu_ready = ~full;
  assign push      = cpu_req & cpu_ready;
  assign push_req  = {cpu_addr, cpu_wdata};

  sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Grant decision; held at IDLE during reset so no access leaks out
  always_comb begin
    grant = GR_IDLE;
    if (!rst_n)                               grant = GR_IDLE;
    else if (starve == STARVE_LIM && !empty)  grant = GR_STEAL;
    else if (disp_req)                        grant = GR_DISP;
    else if (!empty)                          grant = GR_WRITE;
  end

  // VRAM port drive; address/data hold their last value when idle
  always_comb begin
    vram_we    = 1'b0;
    vram_addr  = addr_q;
    vram_wdata = wdata_q;
    pop        = 1'b0;
    case (grant)
      GR_DISP: vram_addr = disp_addr;
      GR_WRITE, GR_STEAL: begin
        vram_we    = 1'b1;
        pop        = 1'b1;
        vram_addr  = head.addr;
        vram_wdata = head.data;
      end
      default: ;
    endcase
  end

  // Previous grant: a display grant returns read data one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= GR_IDLE;
    else        last_grant <= grant;
  end

  // Remember the port values so idle cycles keep the bus stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= vram_addr;
      wdata_q <= vram_wdata;
    end
  end

  // Starvation tracking: count full-buffer cycles lost to display reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 starve <= '0;
    else if (pop || !full)      starve <= '0;
    else if (grant == GR_DISP)  starve <= starve + SW'(1);
  end

  // Count display requests refused by a forced write, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (grant == GR_STEAL && disp_req && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign disp_valid = (last_grant == GR_DISP);

  // Last delivered pixel, shown while no new read is returning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata_q <= '0;
    else if (disp_valid) rdata_q <= vram_rdata;
  end

  assign disp_data = disp_valid ? vram_rdata : rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency VRAM model.
module tb_vram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata = '0;
  logic [2:0]    fifo_level;
  logic [15:0]   stall_cnt;

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] wq [$];

  vram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .STARVE_MAX (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .fifo_level (fifo_level),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // VRAM model returns the low address byte; log every committed write
  always @(posedge clk) begin
    vram_rdata <= vram_addr[DW-1:0];
    if (rst_n && vram_we) wq.push_back({vram_addr, vram_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]       exp_we;
    logic [AW+DW-1:0] e;
    int               n, rd;

    // reset, with a display request pending to prove nothing leaks out
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    disp_req = 1'b1; disp_addr = 17'h5;
    repeat (2) tick();
    #1;
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_data", disp_data, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1; disp_req = 1'b0;

    // single write with display idle
    cpu_req = 1'b1; cpu_addr = 17'h10; cpu_wdata = 8'hAB; #1;
    chk("t1_we_before", vram_we, 0);
    tick(); cpu_req = 1'b0; #1;
    chk("t1_we", vram_we, 1);
    chk("t1_addr", vram_addr, 17'h10);
    chk("t1_wdata", vram_wdata, 8'hAB);
    chk("t1_level", fifo_level, 1);
    tick(); #1;
    chk("t1_idle_we", vram_we, 0);
    chk("t1_hold_addr", vram_addr, 17'h10);
    chk("t1_level0", fifo_level, 0);

    // continuous display reads of addresses 0..3
    disp_req = 1'b1; disp_addr = '0; #1;
    chk("t2_addr", vram_addr, 0);
    chk("t2_we", vram_we, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) disp_addr = AW'(i);
      else       disp_req = 1'b0;
      #1;
      chk("t2_valid", disp_valid, 1);
      chk("t2_data", disp_data, i - 1);
    end
    tick(); #1;
    chk("t2_valid_off", disp_valid, 0);
    chk("t2_data_hold", disp_data, 3);

    // fill the FIFO under constant display load, then wait for the steal
    disp_req = 1'b1; disp_addr = 17'h20;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_addr = AW'(17'h100 + i); cpu_wdata = DW'(8'hC0 + i);
      tick();
      chk("t3_fill_level", fifo_level, i + 1);
      chk("t3_fill_ready", cpu_ready, (i < 3) ? 1 : 0);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("t3_no_steal", vram_we, 0);
      tick();
    end
    #1;
    chk("t3_steal_we", vram_we, 1);
    chk("t3_steal_addr", vram_addr, 17'h100);
    chk("t3_steal_data", vram_wdata, 8'hC0);
    chk("t3_stall_pre", stall_cnt, 0);
    tick(); #1;
    chk("t3_gap_valid", disp_valid, 0);
    chk("t3_gap_data", disp_data, 8'h20);
    chk("t3_stall", stall_cnt, 1);
    chk("t3_level", fifo_level, 3);
    chk("t3_ready", cpu_ready, 1);
    chk("t3_we_after", vram_we, 0);
    tick(); #1;
    chk("t3_valid_back", disp_valid, 1);
    chk("t3_data_back", disp_data, 8'h20);

    // push while popping at level 2, across the pointer wrap
    disp_req = 1'b0; #1;
    chk("t4_we", vram_we, 1);
    chk("t4_addr", vram_addr, 17'h101);
    tick();
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_addr = AW'(17'h104 + i); cpu_wdata = DW'(8'hC4 + i); #1;
      chk("t4_pop_addr", vram_addr, 17'h102 + i);
      tick();
      chk("t4_level", fifo_level, 2);
    end
    cpu_req = 1'b0; #1;
    chk("t4_drain_addr0", vram_addr, 17'h105);
    tick();
    chk("t4_drain_level1", fifo_level, 1);
    #1;
    chk("t4_drain_addr1", vram_addr, 17'h106);
    tick(); #1;
    chk("t4_drain_level0", fifo_level, 0);
    chk("t4_drain_we", vram_we, 0);
    chk("t4_wq_size", wq.size(), 8);
    if (wq.size() >= 8) begin
      chk("t4_order0", wq[0], {17'h10, 8'hAB});
      for (int i = 0; i < 7; i++) begin
        e = {AW'(17'h100 + i), DW'(8'hC0 + i)};
        chk("t4_order", wq[i+1], e);
      end
    end

    // reset with three writes buffered
    disp_req = 1'b1; disp_addr = 17'h40;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_addr = AW'(17'h200 + i); cpu_wdata = DW'(8'hE0 + i);
      tick();
    end
    cpu_req = 1'b0; #1;
    chk("t5_level_pre", fifo_level, 3);
    n = wq.size();
    rst_n = 1'b0; #1;
    chk("t5_level", fifo_level, 0);
    chk("t5_ready", cpu_ready, 1);
    chk("t5_we", vram_we, 0);
    chk("t5_addr", vram_addr, 0);
    chk("t5_stall", stall_cnt, 0);
    chk("t5_valid", disp_valid, 0);
    disp_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    #1;
    chk("t5_no_write", wq.size(), n);
    chk("t5_we_after", vram_we, 0);
    chk("t5_level_after", fifo_level, 0);

    // display request toggling every cycle with writes pending
    disp_req = 1'b1; disp_addr = 17'h50;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_addr = AW'(17'h300 + i); cpu_wdata = DW'(8'hD0 + i);
      tick();
    end
    cpu_req = 1'b0;
    exp_we = 8'b0010_1010;
    rd = 0;
    for (int i = 0; i < 8; i++) begin
      disp_req = (i % 2 == 0); #1;
      chk("t6_we", vram_we, exp_we[i]);
      tick();
      chk("t6_valid", disp_valid, disp_req);
      if (disp_valid) rd++;
    end
    chk("t6_reads", rd, 4);
    n = wq.size();
    if (n >= 3) begin
      for (int k = 0; k < 3; k++) begin
        e = {AW'(17'h300 + k), DW'(8'hD0 + k)};
        chk("t6_order", wq[n-3+k], e);
      end
    end else begin
      chk("t6_wq_size", n, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
